// File: rtl/debounce_pkg.sv
// Shared timing constants, hold-phase encoding and width helpers for the
// push-button debouncer bank.
package debounce_pkg;

  localparam int STABLE_20MS_100M  = 2_000_000;
  localparam int HOLD_1S_100M      = 100_000_000;
  localparam int REPEAT_200MS_100M = 20_000_000;

  typedef enum logic [1:0] {
    PH_HOLD,
    PH_REPEAT,
    PH_DONE
  } hold_phase_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debouncer channel: 2-FF synchroniser, stability counter, clean level,
// press/release pulses and long-press / auto-repeat detection.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int STABLE_CYC = STABLE_20MS_100M,
  parameter int HOLD_CYC   = HOLD_1S_100M,
  parameter int REPEAT_CYC = REPEAT_200MS_100M,
  parameter bit INV        = 1'b0
) (
  input  logic clk,
  input  logic n_rst,
  input  logic btn_i,
  output logic btn_o,
  output logic rise_o,
  output logic fall_o,
  output logic long_o
);

  localparam int CW = clog2(STABLE_CYC);
  localparam int HW = clog2(maxInt(HOLD_CYC, REPEAT_CYC) + 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYC - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYC - 1);
  localparam logic [HW-1:0] REPEAT_LAST = HW'((REPEAT_CYC > 0) ? REPEAT_CYC - 1 : 0);

  logic          s1_q, s2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  hold_phase_e   phase_q, phase_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          long_q, long_d;
  logic          mismatch;
  logic          toggle;

  assign mismatch = (s2_q != level_q);
  assign toggle   = mismatch && (cnt_q == STABLE_LAST);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      hcnt_q  <= '0;
      phase_q <= PH_HOLD;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      s1_q    <= btn_i ^ INV;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      hcnt_q  <= hcnt_d;
      phase_q <= phase_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      long_q  <= long_d;
    end
  end

  // Any matching sample (a bounce) restarts the stability count from zero.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (toggle) begin
      level_d = s2_q;
    end else if (mismatch) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // The hold count restarts on every toggle and idles at zero while released;
  // after the first long pulse it counts repeat periods, or parks when repeat is off.
  always_comb begin
    hcnt_d  = '0;
    phase_d = PH_HOLD;
    if (level_q && !toggle) begin
      case (phase_q)
        PH_HOLD: begin
          if (hcnt_q == HOLD_LAST) begin
            if (REPEAT_CYC > 0) begin
              phase_d = PH_REPEAT;
            end else begin
              hcnt_d  = hcnt_q;
              phase_d = PH_DONE;
            end
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
        PH_REPEAT: begin
          phase_d = PH_REPEAT;
          if (hcnt_q != REPEAT_LAST) hcnt_d = hcnt_q + 1'b1;
        end
        default: begin
          hcnt_d  = hcnt_q;
          phase_d = PH_DONE;
        end
      endcase
    end
  end

  always_comb begin
    rise_d = toggle && s2_q;
    fall_d = toggle && !s2_q;
    long_d = 1'b0;
    if (level_q && !toggle) begin
      if (phase_q == PH_HOLD && hcnt_q == HOLD_LAST) long_d = 1'b1;
      if (phase_q == PH_REPEAT && hcnt_q == REPEAT_LAST) long_d = 1'b1;
    end
  end

  assign btn_o  = level_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign long_o = long_q;

endmodule

// File: rtl/debounce_bank.sv
// NCH-channel debouncer bank for board buttons and switches; each channel is
// an independent debounce_chan with optional pin inversion.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int             NCH        = 4,
  parameter int             STABLE_CYC = STABLE_20MS_100M,
  parameter int             HOLD_CYC   = HOLD_1S_100M,
  parameter int             REPEAT_CYC = REPEAT_200MS_100M,
  parameter logic [NCH-1:0] INV_MASK   = '0
) (
  input  logic           clk,
  input  logic           n_rst,
  input  logic [NCH-1:0] btn_i,
  output logic [NCH-1:0] btn_o,
  output logic [NCH-1:0] rise_o,
  output logic [NCH-1:0] fall_o,
  output logic [NCH-1:0] long_o
);

  if (STABLE_CYC < 2) begin : gStableCheck
    $error("debounce_bank: STABLE_CYC must be >= 2");
  end
  if (HOLD_CYC < 1) begin : gHoldCheck
    $error("debounce_bank: HOLD_CYC must be >= 1");
  end
  if (REPEAT_CYC < 0) begin : gRepeatCheck
    $error("debounce_bank: REPEAT_CYC must be >= 0");
  end

  for (genvar k = 0; k < NCH; k++) begin : gChan
    debounce_chan #(
      .STABLE_CYC(STABLE_CYC),
      .HOLD_CYC  (HOLD_CYC),
      .REPEAT_CYC(REPEAT_CYC),
      .INV       (INV_MASK[k])
    ) uChan (
      .clk   (clk),
      .n_rst (n_rst),
      .btn_i (btn_i[k]),
      .btn_o (btn_o[k]),
      .rise_o(rise_o[k]),
      .fall_o(fall_o[k]),
      .long_o(long_o[k])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank: directed vector tables, hand-written
// corner sequences and randomized stimulus against a behavioural model.
module tb_debounce_bank;

  localparam int         NCH    = 4;
  localparam int         STABLE = 4;
  localparam int         HOLD   = 10;
  localparam int         REPEAT = 3;
  localparam logic [3:0] INVM   = 4'b1000;
  localparam logic [3:0] IDLE   = 4'b1000;

  logic       clk;
  logic       n_rst;
  logic [3:0] btn_i;
  logic [3:0] btn_o, rise_o, fall_o, long_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       nrst;
    logic [3:0] btn;
    logic [3:0] eBtn;
    logic [3:0] eRise;
    logic [3:0] eFall;
    logic [3:0] eLong;
  } vec_t;

  vec_t tbl[$];

  // Model state: synchroniser stages, disagreement run length, edges held.
  logic       mS1[NCH];
  logic       mS2[NCH];
  logic       mLvl[NCH];
  int         mRun[NCH];
  int         mHeld[NCH];
  logic [3:0] mBtn, mRise, mFall, mLong;

  debounce_bank #(
    .NCH       (NCH),
    .STABLE_CYC(STABLE),
    .HOLD_CYC  (HOLD),
    .REPEAT_CYC(REPEAT),
    .INV_MASK  (INVM)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .btn_i (btn_i),
    .btn_o (btn_o),
    .rise_o(rise_o),
    .fall_o(fall_o),
    .long_o(long_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // A long pulse is due HOLD edges after the press and every REPEAT edges after that.
  task automatic modelStep(input logic nrst, input logic [3:0] btn);
    logic x, newLvl, tog;
    for (int k = 0; k < NCH; k++) begin
      if (!nrst) begin
        mS1[k] = 0; mS2[k] = 0; mLvl[k] = 0; mRun[k] = 0; mHeld[k] = 0;
        mRise[k] = 0; mFall[k] = 0; mLong[k] = 0;
      end else begin
        x      = btn[k] ^ INVM[k];
        newLvl = mLvl[k];
        tog    = 0;
        if (mS2[k] != mLvl[k]) begin
          mRun[k]++;
          if (mRun[k] == STABLE) begin
            tog     = 1;
            mRun[k] = 0;
            newLvl  = mS2[k];
          end
        end else begin
          mRun[k] = 0;
        end
        mRise[k] = tog && newLvl;
        mFall[k] = tog && !newLvl;
        if (tog) mHeld[k] = 0;
        else if (mLvl[k]) mHeld[k]++;
        mLong[k] = mLvl[k] && !tog &&
                   (mHeld[k] == HOLD ||
                    (REPEAT > 0 && mHeld[k] > HOLD && (mHeld[k] - HOLD) % REPEAT == 0));
        mLvl[k] = newLvl;
        mS2[k]  = mS1[k];
        mS1[k]  = x;
      end
      mBtn[k] = mLvl[k];
    end
  endtask

  task automatic applyStimulus(input logic nrst, input logic [3:0] btn);
    n_rst = nrst;
    btn_i = btn;
    @(posedge clk);
    modelStep(nrst, btn);
    #1;
    cmp("model btn_o", btn_o, mBtn);
    cmp("model rise_o", rise_o, mRise);
    cmp("model fall_o", fall_o, mFall);
    cmp("model long_o", long_o, mLong);
  endtask

  task automatic checkOutput(input string name, input logic [3:0] eBtn, input logic [3:0] eRise,
                             input logic [3:0] eFall, input logic [3:0] eLong);
    cmp({name, " btn_o"}, btn_o, eBtn);
    cmp({name, " rise_o"}, rise_o, eRise);
    cmp({name, " fall_o"}, fall_o, eFall);
    cmp({name, " long_o"}, long_o, eLong);
  endtask

  task automatic runTable(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].nrst, tbl[i].btn);
      checkOutput($sformatf("%s[%0d]", name, i), tbl[i].eBtn, tbl[i].eRise,
                  tbl[i].eFall, tbl[i].eLong);
    end
    tbl.delete();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, IDLE);
  endtask

  initial begin
    logic [3:0] rb;
    logic       rn;
    n_rst = 1'b0;
    btn_i = IDLE;

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, IDLE);
    checkOutput("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    idle(3);

    $display("[TB] clean press on channel 0");
    for (int i = 0; i < 6; i++)
      tbl.push_back('{1'b1, 4'b1001, (i == 5) ? 4'b0001 : 4'b0000,
                      (i == 5) ? 4'b0001 : 4'b0000, 4'b0000, 4'b0000});
    runTable("press");

    $display("[TB] long press with auto-repeat on channel 0");
    for (int j = 1; j <= 20; j++) begin
      applyStimulus(1'b1, 4'b1001);
      checkOutput($sformatf("long j=%0d", j), 4'b0001, 4'b0000, 4'b0000,
                  (j == 10 || j == 13 || j == 16 || j == 19) ? 4'b0001 : 4'b0000);
    end
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, IDLE);
      checkOutput($sformatf("long release k=%0d", k), (k == 5) ? 4'b0000 : 4'b0001,
                  4'b0000, (k == 5) ? 4'b0001 : 4'b0000,
                  (k == 1 || k == 4) ? 4'b0001 : 4'b0000);
    end
    idle(3);

    $display("[TB] bounce on channel 1");
    for (int i = 0; i < 11; i++)
      tbl.push_back('{1'b1, (i == 3) ? 4'b1000 : 4'b1010, (i >= 9) ? 4'b0010 : 4'b0000,
                      (i == 9) ? 4'b0010 : 4'b0000, 4'b0000, 4'b0000});
    runTable("bounce");
    idle(8);

    $display("[TB] release at hold 7, then fall racing the first long pulse");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 4'b1001);
      checkOutput("t4 press", (i == 5) ? 4'b0001 : 4'b0000, (i == 5) ? 4'b0001 : 4'b0000,
                  4'b0000, 4'b0000);
    end
    applyStimulus(1'b1, 4'b1001);
    checkOutput("t4 held", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, IDLE);
      checkOutput("t4 release7", (i == 5) ? 4'b0000 : 4'b0001, 4'b0000,
                  (i == 5) ? 4'b0001 : 4'b0000, 4'b0000);
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 4'b1001);
      checkOutput("t4 repress", (i == 5) ? 4'b0001 : 4'b0000, (i == 5) ? 4'b0001 : 4'b0000,
                  4'b0000, 4'b0000);
    end
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 4'b1001);
      checkOutput("t4 reheld", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, IDLE);
      checkOutput("t4 fall wins", (i == 5) ? 4'b0000 : 4'b0001, 4'b0000,
                  (i == 5) ? 4'b0001 : 4'b0000, 4'b0000);
    end
    idle(3);

    $display("[TB] inverted channel 3");
    for (int i = 0; i < 6; i++)
      tbl.push_back('{1'b1, 4'b0000, (i == 5) ? 4'b1000 : 4'b0000,
                      (i == 5) ? 4'b1000 : 4'b0000, 4'b0000, 4'b0000});
    for (int i = 0; i < 6; i++)
      tbl.push_back('{1'b1, IDLE, (i == 5) ? 4'b0000 : 4'b1000, 4'b0000,
                      (i == 5) ? 4'b1000 : 4'b0000, 4'b0000});
    runTable("invert");
    idle(3);

    $display("[TB] reset mid-operation on channel 2");
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 4'b1100);
    checkOutput("t6 pre-reset", 4'b0100, 4'b0100, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 4'b1100);
    checkOutput("t6 in reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 4'b1100);
      checkOutput("t6 after reset", (i == 5) ? 4'b0100 : 4'b0000,
                  (i == 5) ? 4'b0100 : 4'b0000, 4'b0000, 4'b0000);
    end
    idle(8);

    $display("[TB] randomized stimulus");
    rb = IDLE;
    for (int i = 0; i < 1200; i++) begin
      for (int k = 0; k < NCH; k++) begin
        if ($urandom_range(0, (i < 400) ? 5 : 29) == 0) rb[k] = ~rb[k];
      end
      rn = ($urandom_range(0, 299) != 0);
      applyStimulus(rn, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
